// File: rtl/gray2bin_arb_if.sv
// Request/result bundle for the shared Gray-to-binary decoder.
// The slave modport is the arbiter's view; the master drives the requests and consumes the results.
interface gray2bin_arb_if #(
  parameter int REQ_NUM    = 4,
  parameter int DATA_WIDTH = 8
);
  localparam int ID_WIDTH = $clog2(REQ_NUM);

  logic [REQ_NUM-1:0]            req_valid_i;
  logic [REQ_NUM-1:0]            req_ready_o;
  logic [REQ_NUM*DATA_WIDTH-1:0] req_gray_i;
  logic                          res_valid_o;
  logic                          res_ready_i;
  logic [DATA_WIDTH-1:0]         res_bin_o;
  logic [ID_WIDTH-1:0]           res_id_o;

  modport slave (
    input  req_valid_i, req_gray_i, res_ready_i,
    output req_ready_o, res_valid_o, res_bin_o, res_id_o
  );

  modport master (
    output req_valid_i, req_gray_i, res_ready_i,
    input  req_ready_o, res_valid_o, res_bin_o, res_id_o
  );
endinterface

// File: rtl/gray2bin_arb.sv
// Round-robin arbiter in front of a single Gray-to-binary decoder.
// The decoded value lands in a one-entry output register tagged with the winning requester.
module gray2bin_arb #(
  parameter int REQ_NUM    = 4,
  parameter int DATA_WIDTH = 8
) (
  input  logic           clk_i,
  input  logic           rst_i,
  gray2bin_arb_if.slave  bus
);
  localparam int ID_WIDTH = $clog2(REQ_NUM);

  logic                  r_valid;
  logic [DATA_WIDTH-1:0] r_bin;
  logic [ID_WIDTH-1:0]   r_id;
  logic [ID_WIDTH-1:0]   r_rr;

  logic                  w_found;
  logic [ID_WIDTH-1:0]   w_win;
  logic                  w_accept;
  logic                  w_grant;
  logic [REQ_NUM-1:0]    w_ready;
  logic [DATA_WIDTH-1:0] w_gray;
  logic [ID_WIDTH-1:0]   w_rr_next;

  // bin[k] is the XOR of all Gray bits at or above k
  function automatic logic [DATA_WIDTH-1:0] gray_decode(input logic [DATA_WIDTH-1:0] g);
    logic [DATA_WIDTH-1:0] b;
    b = '0;
    for (int k = 0; k < DATA_WIDTH; k++) begin
      b[k] = ^(g >> k);
    end
    return b;
  endfunction

  // Round-robin search starting at r_rr; ready is offered only when the output stage can take it
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    for (int i = 0; i < REQ_NUM; i++) begin
      if (!w_found && bus.req_valid_i[(int'(r_rr) + i) % REQ_NUM]) begin
        w_found = 1'b1;
        w_win   = ID_WIDTH'((int'(r_rr) + i) % REQ_NUM);
      end else begin
        w_found = w_found;
      end
    end
    w_accept  = !r_valid || bus.res_ready_i;
    w_grant   = w_found && w_accept;
    w_gray    = bus.req_gray_i[int'(w_win)*DATA_WIDTH +: DATA_WIDTH];
    w_rr_next = (int'(w_win) == REQ_NUM - 1) ? '0 : w_win + ID_WIDTH'(1);
    if (w_grant) begin
      w_ready = {{(REQ_NUM-1){1'b0}}, 1'b1} << w_win;
    end else begin
      w_ready = '0;
    end
  end

  // Result register and priority pointer; a consume without a new grant only clears valid
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_valid <= 1'b0;
      r_bin   <= '0;
      r_id    <= '0;
      r_rr    <= '0;
    end else if (w_grant) begin
      r_valid <= 1'b1;
      r_bin   <= gray_decode(w_gray);
      r_id    <= w_win;
      r_rr    <= w_rr_next;
    end else if (bus.res_ready_i) begin
      r_valid <= 1'b0;
    end else begin
      r_valid <= r_valid;
    end
  end

  assign bus.req_ready_o = w_ready;
  assign bus.res_valid_o = r_valid;
  assign bus.res_bin_o   = r_bin;
  assign bus.res_id_o    = r_id;
endmodule

// File: tb/tb_gray2bin_arb.sv
// Randomised and directed bench for gray2bin_arb against a table-driven round-robin model.
module tb_gray2bin_arb;
  localparam int N = 4;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  logic [W-1:0] inv [256];
  logic [31:0]  gsave;

  gray2bin_arb_if #(.REQ_NUM(N), .DATA_WIDTH(W)) bus ();

  gray2bin_arb #(.REQ_NUM(N), .DATA_WIDTH(W)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Reference model: inverse of n -> n^(n>>1) table, round-robin over a plain integer pointer
  initial begin : model
    int m_rr, m_id, win;
    logic m_valid, accept;
    logic [W-1:0] m_bin;
    logic [N-1:0] exp_rdy;
    for (int n = 0; n < 256; n++) inv[n ^ (n >> 1)] = 8'(n);
    m_rr = 0; m_id = 0; m_valid = 1'b0; m_bin = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        m_rr = 0; m_id = 0; m_valid = 1'b0; m_bin = '0;
      end
      chk("model_res_valid", 32'(bus.res_valid_o), 32'(m_valid));
      chk("model_res_bin", 32'(bus.res_bin_o), 32'(m_bin));
      chk("model_res_id", 32'(bus.res_id_o), 32'(m_id));
      accept = !m_valid || bus.res_ready_i;
      win = -1;
      for (int i = 0; i < N; i++) begin
        if (win < 0 && bus.req_valid_i[(m_rr + i) % N]) win = (m_rr + i) % N;
      end
      exp_rdy = (accept && win >= 0) ? (4'b0001 << win) : 4'b0000;
      chk("model_req_ready", 32'(bus.req_ready_o), 32'(exp_rdy));
      if (!rst) begin
        if (exp_rdy != 4'b0000) begin
          m_valid = 1'b1;
          m_bin   = inv[bus.req_gray_i[win*W +: W]];
          m_id    = win;
          m_rr    = (win + 1) % N;
        end else if (bus.res_ready_i) begin
          m_valid = 1'b0;
        end
      end
    end
  end

  initial begin : stim
    logic [7:0] sweep_g [4];
    logic [7:0] sweep_b [4];
    sweep_g = '{8'h80, 8'h03, 8'h01, 8'h00};
    sweep_b = '{8'hFF, 8'h02, 8'h01, 8'h00};
    bus.req_valid_i = 4'b0000;
    bus.req_gray_i  = 32'h0;
    bus.res_ready_i = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("reset_valid", 32'(bus.res_valid_o), 32'd0);
    chk("reset_bin", 32'(bus.res_bin_o), 32'd0);
    chk("reset_id", 32'(bus.res_id_o), 32'd0);

    // All requesters valid: grants rotate 0,1,2,3,0,1
    gsave = $urandom;
    bus.req_gray_i  = gsave;
    bus.req_valid_i = 4'b1111;
    bus.res_ready_i = 1'b1;
    #1 chk("rot_ready_first", 32'(bus.req_ready_o), 32'h1);
    for (int k = 0; k < 6; k++) begin
      cyc();
      chk("rot_id", 32'(bus.res_id_o), 32'(k % 4));
      chk("rot_valid", 32'(bus.res_valid_o), 32'd1);
    end

    // Backpressure holds id 1 for three cycles, then release grants 2 immediately
    bus.res_ready_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("bp_ready", 32'(bus.req_ready_o), 32'h0);
      chk("bp_id", 32'(bus.res_id_o), 32'd1);
      chk("bp_bin", 32'(bus.res_bin_o), 32'(inv[gsave[15:8]]));
      cyc();
    end
    bus.res_ready_i = 1'b1;
    #1 chk("release_ready", 32'(bus.req_ready_o), 32'h4);
    cyc();
    chk("release_id", 32'(bus.res_id_o), 32'd2);
    bus.req_valid_i = 4'b0010;
    #1 chk("only1_ready", 32'(bus.req_ready_o), 32'h2);
    cyc();

    // Pointer now at 2 with requesters 1 and 3 valid: 3, 1, 3
    bus.req_valid_i = 4'b1010;
    #1 chk("r13_ready_a", 32'(bus.req_ready_o), 32'h8);
    cyc();
    chk("r13_id_a", 32'(bus.res_id_o), 32'd3);
    chk("r13_ready_b", 32'(bus.req_ready_o), 32'h2);
    cyc();
    chk("r13_id_b", 32'(bus.res_id_o), 32'd1);
    chk("r13_ready_c", 32'(bus.req_ready_o), 32'h8);
    cyc();
    chk("r13_id_c", 32'(bus.res_id_o), 32'd3);

    // Single requester 2 with gray 0C decodes to 08
    bus.req_valid_i = 4'b0100;
    bus.req_gray_i[23:16] = 8'h0C;
    #1 chk("single_ready", 32'(bus.req_ready_o), 32'h4);
    cyc();
    bus.req_valid_i = 4'b0000;
    #1;
    chk("single_valid", 32'(bus.res_valid_o), 32'd1);
    chk("single_bin", 32'(bus.res_bin_o), 32'h08);
    chk("single_id", 32'(bus.res_id_o), 32'd2);

    // Pin the model's decode table to hand-computed values
    chk("pin_inv_0c", 32'(inv[8'h0C]), 32'h08);
    chk("pin_inv_55", 32'(inv[8'h55]), 32'h66);

    // Decode sweep on requester 0
    bus.req_valid_i = 4'b0001;
    for (int k = 0; k < 4; k++) begin
      bus.req_gray_i[7:0] = sweep_g[k];
      cyc();
      #1 chk("sweep_bin", 32'(bus.res_bin_o), 32'(sweep_b[k]));
      chk("pin_inv_sweep", 32'(inv[sweep_g[k]]), 32'(sweep_b[k]));
    end
    for (int n = 0; n < 256; n++) begin
      bus.req_gray_i[7:0] = 8'(n);
      cyc();
    end

    // Random traffic with random backpressure
    for (int k = 0; k < 400; k++) begin
      bus.req_valid_i = 4'($urandom_range(0, 15));
      bus.req_gray_i  = $urandom;
      bus.res_ready_i = ($urandom_range(0, 3) != 0);
      cyc();
    end

    // Reset while a result is pending
    bus.res_ready_i = 1'b1;
    bus.req_valid_i = 4'b1000;
    bus.req_gray_i[31:24] = 8'h55;
    cyc();
    bus.res_ready_i = 1'b0;
    bus.req_valid_i = 4'b1111;
    #1;
    chk("pre_rst_valid", 32'(bus.res_valid_o), 32'd1);
    chk("pre_rst_bin", 32'(bus.res_bin_o), 32'h66);
    chk("pre_rst_id", 32'(bus.res_id_o), 32'd3);
    rst = 1'b1;
    #1;
    chk("async_rst_valid", 32'(bus.res_valid_o), 32'd0);
    chk("async_rst_bin", 32'(bus.res_bin_o), 32'd0);
    chk("async_rst_id", 32'(bus.res_id_o), 32'd0);
    cyc();
    rst = 1'b0;
    bus.res_ready_i = 1'b1;
    #1 chk("post_rst_ready", 32'(bus.req_ready_o), 32'h1);
    cyc();
    chk("post_rst_id", 32'(bus.res_id_o), 32'd0);
    chk("post_rst_valid", 32'(bus.res_valid_o), 32'd1);

    repeat (2) cyc();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/gray2bin_arb.md
Name: gray2bin_arb

Overview:
- Shares a single Gray-to-binary decode datapath between REQ_NUM requesters.
- Requesters present Gray-coded values with valid/ready. A round-robin arbiter grants one per cycle, and the decoded binary value goes into a one-entry output register tagged with the requester ID.
- Sits between multiple Gray-pointer sources (e.g. FIFO pointer snapshots, Gray counters) and a single consumer, saving per-source decoders.

Parameters:
- REQ_NUM, 4: number of requesters, must be >= 2.
- DATA_WIDTH, 8: width of each Gray input and of the binary result, must be >= 1.
- ID_WIDTH (localparam), $clog2(REQ_NUM): width of the result ID.

Ports:
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_i  input  1  asynchronous reset, active-high.
- req_valid_i  input  REQ_NUM  per-requester valid.
- req_ready_o  output  REQ_NUM  per-requester ready; one-hot or zero.
- req_gray_i  input  REQ_NUM*DATA_WIDTH  flat Gray inputs; requester i occupies [i*DATA_WIDTH +: DATA_WIDTH].
- res_valid_o  output  1  result register holds valid data.
- res_ready_i  input  1  consumer accepts the result.
- res_bin_o  output  DATA_WIDTH  decoded binary value.
- res_id_o  output  ID_WIDTH  index of the requester that produced res_bin_o.

Behaviour:
- Reset (async assert, sync-safe deassert by the system) sets:
  - res_valid_o=0, res_bin_o=0, res_id_o=0.
  - Round-robin pointer rr_q=0, so requester 0 has highest priority first.
- Decode rule: bin[k] = XOR of gray[DATA_WIDTH-1:k] for every bit k, applied to the selected requester only.
- Output stage can accept when accept = !res_valid_o || res_ready_i. This allows full throughput, one result per cycle.
- Arbitration (combinational):
  - Search req_valid_i starting at index rr_q, wrapping modulo REQ_NUM.
  - The first valid index is the winner w.
  - req_ready_o[w]=1 only if accept=1. All other req_ready_o bits are 0.
  - req_ready_o never depends on res_valid_o alone without res_ready_i.
- Request handshake (req_valid_i[w] && req_ready_o[w]) at edge:
  - res_bin_o <= decode(req_gray_i[w]), res_id_o <= w, res_valid_o <= 1.
  - rr_q <= (w+1) mod REQ_NUM, wrapping from REQ_NUM-1 to 0.
- Result consumed (res_valid_o && res_ready_i) with no new grant in the same cycle:
  - res_valid_o <= 0.
  - res_bin_o and res_id_o hold their last values.
- Simultaneous consume and grant: new result loaded, res_valid_o stays 1, no bubble.
- Backpressure (res_valid_o=1, res_ready_i=0):
  - All req_ready_o = 0.
  - res_bin_o and res_id_o stable.
  - rr_q unchanged.
- No valid requests: no grant, rr_q unchanged.
- Latency: 1 cycle from request handshake to res_valid_o.
- Fairness: with all requesters continuously valid and no backpressure, grants rotate 0,1,...,REQ_NUM-1,0. Each requester waits at most REQ_NUM-1 grants.
- Requester obligation: a requester may drop valid without being granted (no stickiness required). The arbiter must not rely on valid being held.
- Reset mid-operation: pending result discarded, outputs return to reset values immediately (async), and rr_q returns to 0.
- Width edge: DATA_WIDTH=1 makes decode the identity.

Test Plan:
- Single requester 2 valid, gray=8'h0C, res_ready_i=1 -> req_ready_o=4'b0100 in the same cycle; next cycle res_valid_o=1, res_bin_o=8'h08, res_id_o=2.
- Decode sweep on requester 0: gray 8'h80 -> 8'hFF; 8'h03 -> 8'h02; 8'h01 -> 8'h01; 8'h00 -> 8'h00. Also all 256 codes against a reference model.
- All four valid continuously, res_ready_i=1 -> res_id_o sequence 0,1,2,3,0,1 on consecutive cycles; res_valid_o stays high throughout.
- Result pending with res_ready_i=0 for 3 cycles while all requesters valid -> req_ready_o=0 each cycle, res_bin_o/res_id_o stable. When res_ready_i=1, the next grant goes to (last id+1) mod 4 in the same cycle.
- Requesters 1 and 3 valid, rr_q=2 -> requester 3 granted first, then 1, then 3.
- rst_i pulsed while res_valid_o=1 -> res_valid_o, res_bin_o, res_id_o go to 0 asynchronously. After release, with all requesters valid, requester 0 is granted first.
